// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin write-port arbiter for the async FIFO write side.
// A requester that wins keeps the grant until the last word of its frame is written.
// Each finished frame is followed by one idle arbitration cycle.
// Optional watchdog: define ARB_TIMEOUT_EN to release an owner that stops
// presenting data (not counting FIFO-full stalls) for TIMEOUT_CYCLES cycles.
module fifo_wr_arbiter #(
  parameter int DATA_WIDTH     = 8,
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [NUM_REQ-1:0]            REQ_VALID,
  input  logic [NUM_REQ-1:0]            REQ_LAST,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] REQ_DATA,
  output logic [NUM_REQ-1:0]            REQ_READY,
  input  logic                          FIFO_FULL,
  output logic [DATA_WIDTH-1:0]         FIFO_WR_DATA,
  output logic                          FIFO_W_INC,
  output logic [NUM_REQ-1:0]            GRANT,
  output logic                          BUSY,
  output logic                          TIMEOUT_ERR
);

  localparam int PW = (NUM_REQ > 2) ? 2 : 1;

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_LOCKED = 1'b1;

  if (NUM_REQ < 2 || NUM_REQ > 4) begin : g_bad_num_req
    $error("fifo_wr_arbiter: NUM_REQ must be in 2..4");
  end
  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("fifo_wr_arbiter: TIMEOUT_CYCLES must be in 2..255");
  end

  logic [0:0]            r_state;
  logic [NUM_REQ-1:0]    r_grant;
  logic [PW-1:0]         r_owner;
  logic [PW-1:0]         r_ptr;

  logic                  w_locked;
  logic                  w_any;
  logic [PW-1:0]         w_pick;
  logic                  w_own_valid;
  logic                  w_own_last;
  logic [DATA_WIDTH-1:0] w_own_data;
  logic                  w_accept;
  logic                  w_done;
  logic                  w_timeout;

  // Wrap-around successor of a requester index, used for the next priority pointer.
  function automatic logic [PW-1:0] f_next(input logic [PW-1:0] idx);
    int n;
    n = int'(idx) + 1;
    if (n >= NUM_REQ) n = 0;
    return PW'(n);
  endfunction

  // Round-robin pick: first valid requester at or after the pointer, wrapping.
  always_comb begin
    int idx;
    w_any  = 1'b0;
    w_pick = '0;
    idx    = 0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = (int'(r_ptr) + i) % NUM_REQ;
      if (REQ_VALID[idx]) begin
        w_any  = 1'b1;
        w_pick = PW'(idx);
      end
    end
  end

  // Owner-side mux driven by the one-hot grant (zero when no one holds it).
  always_comb begin
    w_own_valid = |(REQ_VALID & r_grant);
    w_own_last  = |(REQ_LAST & r_grant);
    w_own_data  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (r_grant[k]) w_own_data = REQ_DATA[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign w_locked     = (r_state == S_LOCKED);
  assign REQ_READY    = (w_locked && !FIFO_FULL) ? r_grant : '0;
  assign FIFO_W_INC   = w_locked & w_own_valid & ~FIFO_FULL;
  assign FIFO_WR_DATA = w_locked ? w_own_data : '0;
  assign w_accept     = FIFO_W_INC;
  assign w_done       = w_accept & w_own_last;
  assign GRANT        = r_grant;
  assign BUSY         = w_locked;

`ifdef ARB_TIMEOUT_EN
  logic [7:0] r_stall;
  logic       r_terr;
  logic       w_stall_cyc;

  // Only cycles where the owner has nothing to offer and the FIFO could take it count as stalls.
  assign w_stall_cyc = w_locked & ~w_own_valid & ~FIFO_FULL;
  assign w_timeout   = w_stall_cyc && (r_stall == 8'(TIMEOUT_CYCLES - 1));
  assign TIMEOUT_ERR = r_terr;

  // Stall counter and one-cycle error pulse on watchdog release.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_stall <= '0;
      r_terr  <= 1'b0;
    end else begin
      r_terr <= w_timeout;
      if (!w_locked || w_accept || w_timeout) r_stall <= '0;
      else if (w_stall_cyc)                    r_stall <= r_stall + 8'd1;
    end
  end
`else
  assign w_timeout   = 1'b0;
  assign TIMEOUT_ERR = 1'b0;
`endif

  // Arbitration FSM: IDLE registers the winner, LOCKED holds it until the frame ends.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= S_IDLE;
      r_grant <= '0;
      r_owner <= '0;
      r_ptr   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_state <= S_LOCKED;
            r_grant <= {{(NUM_REQ-1){1'b0}}, 1'b1} << w_pick;
            r_owner <= w_pick;
          end
        end
        S_LOCKED: begin
          if (w_done || w_timeout) begin
            r_state <= S_IDLE;
            r_grant <= '0;
            r_ptr   <= f_next(r_owner);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_grant <= '0;
        end
      endcase
    end
  end

endmodule
